uart_tx_fifo: RTL

//   Byte FIFO and launch sequencer directly upstream of the UART transmitter.

---
 rtl/uart_tx_fifo.sv | 136 +++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte queue in front of uart_tx plus a launch sequencer that
// issues one tx_start per frame and paces itself on tx_busy.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          tx_en,
    input  logic          tx_busy,
    output logic          tx_start,
    output logic [7:0]    data_out,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          idle
);

    localparam int unsigned DW = 8;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [DW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push_c;
    logic            pop_c;
    logic            tx_start_d;
    logic [CW-1:0]   count_d;

    // A push is accepted only when the queue is not full before the edge;
    // a simultaneous pop does not make room.
    assign push_c = wr_en && (count != DEPTH_C);

    // Launch state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Launch next-state: pop and pulse from IDLE, then track one busy frame
    always_comb begin
        state_d    = state_q;
        pop_c      = 1'b0;
        tx_start_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tx_en && !empty && !tx_busy) begin
                    pop_c      = 1'b1;
                    tx_start_d = 1'b1;
                    state_d    = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Occupancy after this edge; push and pop together leave it unchanged
    always_comb begin
        count_d = count;
        if (push_c && !pop_c) begin
            count_d = count + CW'(1);
        end else if (!push_c && pop_c) begin
            count_d = count - CW'(1);
        end
    end

    // Pointers, status flags and registered launch outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
            idle     <= 1'b1;
            tx_start <= 1'b0;
            data_out <= '0;
        end else begin
            count    <= count_d;
            empty    <= (count_d == '0);
            full     <= (count_d == DEPTH_C);
            idle     <= (count_d == '0) && (state_d == S_IDLE) && !tx_busy;
            tx_start <= tx_start_d;
            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr   <= rd_ptr + AW'(1);
                data_out <= mem[rd_ptr];
            end
            if (wr_en && (count == DEPTH_C)) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage array; contents need no reset since reads are gated by count
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule
